// File: rtl/scs8hd_rf_wrarb.sv
// scs8hd_rf_wrarb: round-robin write arbiter for an enable-flop register bank.
// NREQ requesters compete. The single registered winner drives one DE line and
// the D bus for one cycle. Out-of-range addresses pulse err and raise no DE.
// Optional burst locking is compiled in with `define SCS8HD_WRARB_LOCK_EN.
module scs8hd_rf_wrarb #(
    parameter int NREQ     = 4,
    parameter int NWORD    = 8,
    parameter int AW       = 3,
    parameter int DW       = 8,
    parameter int MAXBURST = 4
) (
    input  logic               CLK,
    input  logic               RESETB,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
`ifdef SCS8HD_WRARB_LOCK_EN
    input  logic [NREQ-1:0]    lock,
`endif
    output logic [NREQ-1:0]    gnt,
    output logic [NWORD-1:0]   de,
    output logic [DW-1:0]      d,
    output logic               err
);

    localparam int          IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] NWORD_L = (AW+1)'(NWORD);

    if ((1 << AW) < NWORD) begin : g_aw_check
        $error("AW too narrow to address NWORD words");
    end
    if (MAXBURST < 1) begin : g_burst_check
        $error("MAXBURST must be at least 1");
    end

`ifdef SCS8HD_WRARB_LOCK_EN
    localparam int CW = $clog2(MAXBURST + 1);
    typedef enum logic [1:0] {IDLE, GRANT, BURST} state_t;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [0:0] {IDLE, GRANT} state_t;
`endif

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NWORD-1:0] de_q, de_d;
    logic [DW-1:0]    d_q, d_d;
    logic             err_q, err_d;

    logic [NREQ-1:0]  req_avail;
    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic             sel_vld;
    logic [IW-1:0]    sel_idx;
    logic [AW-1:0]    sel_addr;

    // Round-robin search starting at ptr_q; a requester granted this cycle sits out one cycle.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        req_avail = (state_q == IDLE) ? req : (req & ~gnt_q);
        win_vld   = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % 32'(NREQ);
            if (!win_vld && req_avail[idx]) begin
                win_vld = 1'b1;
                win_idx = IW'(idx);
            end
        end
    end

    // Next-state, pointer, burst counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        de_d    = '0;
        d_d     = d_q;
        err_d   = 1'b0;
        sel_vld = 1'b0;
        sel_idx = win_idx;
`ifdef SCS8HD_WRARB_LOCK_EN
        owner_d = owner_q;
        cnt_d   = '0;
        // A locked owner bypasses the grant mask; the pointer was already moved past it.
        if (state_q != IDLE && lock[owner_q] && req[owner_q] && cnt_q < CW'(MAXBURST)) begin
            state_d = BURST;
            sel_vld = 1'b1;
            sel_idx = owner_q;
            cnt_d   = cnt_q + CW'(1);
        end else
`endif
        if (win_vld) begin
            state_d = GRANT;
            sel_vld = 1'b1;
            sel_idx = win_idx;
            ptr_d   = (32'(win_idx) == 32'(NREQ - 1)) ? '0 : win_idx + IW'(1);
`ifdef SCS8HD_WRARB_LOCK_EN
            owner_d = win_idx;
            cnt_d   = CW'(1);
`endif
        end else begin
            state_d = IDLE;
        end

        sel_addr = addr[32'(sel_idx)*AW +: AW];
        if (sel_vld) begin
            gnt_d[sel_idx] = 1'b1;
            if ({1'b0, sel_addr} < NWORD_L) begin
                for (int unsigned w = 0; w < NWORD; w++) begin
                    de_d[w] = ({1'b0, sel_addr} == (AW+1)'(w));
                end
                d_d = wdata[32'(sel_idx)*DW +: DW];
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State and output registers; reset clears everything, aborting any burst.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            de_q    <= '0;
            d_q     <= '0;
            err_q   <= 1'b0;
`ifdef SCS8HD_WRARB_LOCK_EN
            owner_q <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            de_q    <= de_d;
            d_q     <= d_d;
            err_q   <= err_d;
`ifdef SCS8HD_WRARB_LOCK_EN
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign gnt = gnt_q;
    assign de  = de_q;
    assign d   = d_q;
    assign err = err_q;

endmodule

// File: tb/tb_scs8hd_rf_wrarb.sv
// Testbench for scs8hd_rf_wrarb: an 8-word and a 6-word instance share stimulus.
// A behavioural model (integer pointer, last-grant set, burst count) predicts outputs.
`timescale 1ns/1ps
module tb_scs8hd_rf_wrarb;

`ifdef SCS8HD_WRARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESETB;
    logic [3:0]  req, lock;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt8, gnt6;
    logic [7:0]  de8, d8, d6;
    logic [5:0]  de6;
    logic        err8, err6;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    int         m_ptr, m_owner, m_cnt;
    logic [3:0] m_gnt;
    logic [7:0] m_de8, m_d8, m_d6;
    logic [5:0] m_de6;
    logic       m_err8, m_err6;
    bit         m_d6_known;

    logic [7:0] bank [8];

    scs8hd_rf_wrarb #(.NREQ(4), .NWORD(8), .AW(3), .DW(8), .MAXBURST(4)) u_dut8 (
        .CLK(CLK), .RESETB(RESETB), .req(req), .addr(addr), .wdata(wdata),
`ifdef SCS8HD_WRARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt8), .de(de8), .d(d8), .err(err8)
    );

    scs8hd_rf_wrarb #(.NREQ(4), .NWORD(6), .AW(3), .DW(8), .MAXBURST(4)) u_dut6 (
        .CLK(CLK), .RESETB(RESETB), .req(req), .addr(addr), .wdata(wdata),
`ifdef SCS8HD_WRARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt6), .de(de6), .d(d6), .err(err6)
    );

    always #5 CLK = ~CLK;

    // register bank written by the 8-word instance
    always @(posedge CLK) begin
        for (int w = 0; w < 8; w++) if (de8[w]) bank[w] <= d8;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1);
    end

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_gnt = '0;
        m_de8 = '0; m_de6 = '0; m_d8 = '0; m_d6 = '0;
        m_err8 = 1'b0; m_err6 = 1'b0; m_d6_known = 1'b1;
    endtask

    // One clock of the behavioural model using the currently driven inputs.
    task automatic model_step();
        int win;
        int a;
        win = -1;
        if (LOCK_EN && m_gnt != 0 && lock[m_owner] && req[m_owner] && m_cnt < 4) begin
            win = m_owner;
            m_cnt++;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (win < 0 && req[i] && !m_gnt[i]) win = i;
            end
            if (win >= 0) begin
                m_ptr = (win + 1) % 4; m_owner = win; m_cnt = 1;
            end else begin
                m_cnt = 0;
            end
        end
        m_gnt = '0; m_de8 = '0; m_de6 = '0; m_err8 = 1'b0; m_err6 = 1'b0;
        if (win >= 0) begin
            m_gnt[win] = 1'b1;
            a = int'(addr[win*3 +: 3]);
            m_de8[a] = 1'b1;
            m_d8 = wdata[win*8 +: 8];
            if (a < 6) begin
                m_de6[a] = 1'b1; m_d6 = wdata[win*8 +: 8]; m_d6_known = 1'b1;
            end else begin
                m_err6 = 1'b1; m_d6_known = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESETB = 1'b0; req = '0; lock = '0; addr = '0; wdata = '0;
        model_reset();
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        RESETB = 1'b1;
    endtask

    task automatic test_reset();
        RESETB = 1'b0; req = '0; lock = '0; addr = '0; wdata = '0;
        model_reset();
        #1;
        n_total++;
        if ({gnt8, de8, d8, err8, gnt6, de6, d6, err6} !== '0)
            $display("FAIL reset_initial: got gnt=%b de=%b d=%h err=%b, required all zero", gnt8, de8, d8, err8);
        else n_pass++;
        apply_reset();
        req = 4'b1111; addr = {3'd4, 3'd3, 3'd2, 3'd1}; wdata = 32'h44332211;
        tick(); tick();
        @(negedge CLK);
        RESETB = 1'b0;
        model_reset();
        #1;
        n_total++;
        if ({gnt8, de8, d8, err8, gnt6, de6, d6, err6} !== '0)
            $display("FAIL reset_async: got gnt=%b de=%b d=%h err=%b, required all zero", gnt8, de8, d8, err8);
        else n_pass++;
        @(posedge CLK); #1;
        n_total++;
        if ({gnt8, de8, err8} !== '0)
            $display("FAIL reset_held: got gnt=%b de=%b err=%b, required zero", gnt8, de8, err8);
        else n_pass++;
        @(negedge CLK);
        RESETB = 1'b1;
        tick();
        n_total++;
        if (gnt8 !== 4'b0001 || gnt6 !== 4'b0001)
            $display("FAIL reset_first_grant: got %b/%b, required 0001", gnt8, gnt6);
        else n_pass++;
        n_total++;
        if (de8 !== 8'h02 || d8 !== 8'h11)
            $display("FAIL reset_first_data: got de=%b d=%h, required de=00000010 d=11", de8, d8);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        logic [7:0] exp_de [5];
        exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_de = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h02};
        apply_reset();
        req = 4'b1111; addr = {3'd4, 3'd3, 3'd2, 3'd1}; wdata = 32'h44332211;
        for (int s = 0; s < 5; s++) begin
            tick();
            n_total++;
            if (gnt8 !== exp_g[s] || de8 !== exp_de[s])
                $display("FAIL round_robin[%0d]: got gnt=%b de=%b, required gnt=%b de=%b", s, gnt8, de8, exp_g[s], exp_de[s]);
            else n_pass++;
        end
    endtask

    task automatic test_masking();
        logic [3:0] exp_g [4];
        exp_g = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
        apply_reset();
        req = 4'b0001; addr = 12'd3; wdata = 32'h0000_005A;
        for (int s = 0; s < 4; s++) begin
            tick();
            n_total++;
            if (gnt8 !== exp_g[s])
                $display("FAIL masking[%0d]: got gnt=%b, required %b", s, gnt8, exp_g[s]);
            else n_pass++;
        end
        n_total++;
        if (d8 !== 8'h5A)
            $display("FAIL masking_d_hold: got d=%h, required 5a", d8);
        else n_pass++;
    endtask

    task automatic test_range_error();
        apply_reset();
        req = 4'b0100; addr = {3'd0, 3'd7, 3'd0, 3'd0}; wdata = 32'h00C3_0000;
        tick();
        n_total++;
        if (gnt6 !== 4'b0100 || de6 !== 6'b0 || err6 !== 1'b1)
            $display("FAIL range_err6: got gnt=%b de=%b err=%b, required 0100/000000/1", gnt6, de6, err6);
        else n_pass++;
        n_total++;
        if (gnt8 !== 4'b0100 || de8 !== 8'h80 || err8 !== 1'b0 || d8 !== 8'hC3)
            $display("FAIL range_ok8: got gnt=%b de=%b err=%b d=%h, required 0100/10000000/0/c3", gnt8, de8, err8, d8);
        else n_pass++;
        req = '0;
        tick();
        n_total++;
        if (err6 !== 1'b0 || gnt6 !== 4'b0)
            $display("FAIL range_err_pulse: got err=%b gnt=%b, required 0/0000", err6, gnt6);
        else n_pass++;
    endtask

    task automatic test_datapath();
        apply_reset();
        req = 4'b0001; addr = {9'd0, 3'd5}; wdata = {24'd0, 8'hA5};
        tick();
        n_total++;
        if (de8 !== 8'b0010_0000 || d8 !== 8'hA5 || err8 !== 1'b0)
            $display("FAIL datapath: got de=%b d=%h err=%b, required 00100000/a5/0", de8, d8, err8);
        else n_pass++;
        req = '0;
        tick();
        n_total++;
        if (bank[5] !== 8'hA5)
            $display("FAIL bank_word5: got %h, required a5", bank[5]);
        else n_pass++;
        n_total++;
        if (gnt8 !== 4'b0 || de8 !== 8'b0 || d8 !== 8'hA5)
            $display("FAIL idle_hold: got gnt=%b de=%b d=%h, required 0000/00000000/a5", gnt8, de8, d8);
        else n_pass++;
    endtask

`ifdef SCS8HD_WRARB_LOCK_EN
    task automatic test_burst();
        logic [3:0] exp_g [5];
        exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
        apply_reset();
        req = 4'b1010; lock = 4'b0010; addr = {3'd6, 3'd0, 3'd2, 3'd0}; wdata = 32'h77000011;
        for (int s = 0; s < 5; s++) begin
            tick();
            n_total++;
            if (gnt8 !== exp_g[s])
                $display("FAIL burst[%0d]: got gnt=%b, required %b", s, gnt8, exp_g[s]);
            else n_pass++;
        end
        apply_reset();
        req = 4'b0010; lock = 4'b0010; addr = {3'd0, 3'd0, 3'd2, 3'd0};
        tick(); tick();
        @(negedge CLK);
        RESETB = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (gnt8 !== 4'b0 || de8 !== 8'b0)
            $display("FAIL burst_reset_abort: got gnt=%b de=%b, required zero", gnt8, de8);
        else n_pass++;
        @(negedge CLK);
        RESETB = 1'b1;
    endtask
`endif

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            req   = 4'($urandom) | 4'($urandom);
            lock  = 4'($urandom) | 4'($urandom);
            addr  = 12'($urandom);
            wdata = $urandom;
            tick();
            n_total++;
            if (gnt8 !== m_gnt || gnt6 !== m_gnt)
                $display("FAIL rand_gnt[%0d]: got %b/%b, required %b", c, gnt8, gnt6, m_gnt);
            else n_pass++;
            n_total++;
            if (de8 !== m_de8 || err8 !== m_err8 || d8 !== m_d8)
                $display("FAIL rand_out8[%0d]: got de=%b err=%b d=%h, required de=%b err=%b d=%h", c, de8, err8, d8, m_de8, m_err8, m_d8);
            else n_pass++;
            n_total++;
            if (de6 !== m_de6 || err6 !== m_err6)
                $display("FAIL rand_out6[%0d]: got de=%b err=%b, required de=%b err=%b", c, de6, err6, m_de6, m_err6);
            else n_pass++;
            if (m_d6_known) begin
                n_total++;
                if (d6 !== m_d6)
                    $display("FAIL rand_d6[%0d]: got %h, required %h", c, d6, m_d6);
                else n_pass++;
            end
            n_total++;
            if ($countones(gnt8) > 1 || $countones(de8) > 1)
                $display("FAIL rand_onehot[%0d]: got gnt=%b de=%b, required at most one bit each", c, gnt8, de8);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_masking();
        test_range_error();
        test_datapath();
`ifdef SCS8HD_WRARB_LOCK_EN
        test_burst();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/scs8hd_rf_wrarb.md
SCS8HD_RF_WRARB -- requirements
Module: scs8hd_rf_wrarb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of write requesters.
REQ-002 The block SHALL have parameter NWORD, default 8: number of words in the enable-flop register bank.
REQ-003 The block SHALL have parameter AW, default 3: address width per requester (2^AW >= NWORD).
REQ-004 The block SHALL have parameter DW, default 8: data width per word.
REQ-005 The block SHALL have parameter MAXBURST, default 4: maximum consecutive grants to one locked owner.
REQ-006 The block SHALL have port CLK  input  1: single clock, all state updates on its rising edge.
REQ-007 The block SHALL have port RESETB  input  1: asynchronous, active-low reset.
REQ-008 The block SHALL have port req  input  NREQ: per-requester write request.
REQ-009 The block SHALL have port addr  input  NREQ*AW: packed word addresses, requester i at bits [i*AW +: AW].
REQ-010 The block SHALL have port wdata  input  NREQ*DW: packed write data, requester i at bits [i*DW +: DW].
REQ-011 The block SHALL have port lock  input  NREQ: burst hold request; present only with SCS8HD_WRARB_LOCK_EN.
REQ-012 The block SHALL have port gnt  output  NREQ: one-hot grant pulse, registered.
REQ-013 The block SHALL have port de  output  NWORD: one-hot word enable driving the bank's DE pins, registered.
REQ-014 The block SHALL have port d  output  DW: write data driving the bank's D pins, registered.
REQ-015 The block SHALL have port err  output  1: one-cycle pulse for an out-of-range address, registered.

Function
REQ-016 The block SHALL arbitrate round-robin, with priority starting at the index after the last granted requester.
REQ-017 Latency: req sampled at edge t SHALL produce gnt, de, d and err valid in cycle t+1, for exactly one cycle.
REQ-018 In any cycle, at most one gnt bit and at most one de bit SHALL be high.
REQ-019 req[i] SHALL be masked from arbitration while gnt[i] is high, unless lock[i] is honoured (REQ-023).
REQ-020 Granted addr < NWORD: de[addr] SHALL be 1, d SHALL be the granted wdata, and err SHALL be 0.
REQ-021 Granted addr >= NWORD: gnt SHALL still pulse, de SHALL be all zero, err SHALL be 1, and d SHALL be don't-care.
REQ-022 With no unmasked request, gnt, de and err SHALL be 0, d SHALL hold its last value, and the pointer SHALL be unchanged.
REQ-023 State machine: IDLE (no grant), GRANT (single grant; pointer advances past owner), BURST (owner held; pointer frozen).
REQ-024 Transitions: IDLE->GRANT on any unmasked req; GRANT->BURST if the owner's lock is high and req is held.
REQ-025 BURST exit: BURST->GRANT/IDLE when owner lock or req drops, or when the burst counter reaches MAXBURST; the pointer then advances past the owner.
REQ-026 The burst counter SHALL count grants to the current owner, be ceil(log2(MAXBURST+1)) bits wide, and clear on exit from BURST.

Reset
REQ-027 RESETB low SHALL asynchronously force gnt=0, de=0, d=0, err=0, state IDLE, pointer to requester 0 (highest priority), and burst counter 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no partial de pulse.
REQ-029 First arbitration after reset SHALL occur at the first rising CLK edge with RESETB high.

Configuration
REQ-030 With SCS8HD_WRARB_LOCK_EN defined, the lock port and the BURST state SHALL exist.
REQ-031 Without SCS8HD_WRARB_LOCK_EN, the lock port and burst counter SHALL be absent, and the FSM SHALL use only IDLE and GRANT.

Verification
REQ-032 Reset: drive RESETB low mid-cycle with req=4'b1111 -> all outputs 0 immediately; first grant after release is gnt=4'b0001.
REQ-033 Round-robin: hold req=4'b1111 (re-asserted after masking) -> gnt sequence 0001,0010,0100,1000,0001; de follows each granted addr.
REQ-034 Range error: req[2]=1, addr2=3'd7, NWORD=6 -> next cycle gnt=4'b0100, de=0, err=1.
REQ-035 Burst (LOCK_EN): req[1]=lock[1]=1 held, req[3]=1 -> four consecutive gnt=0010, then gnt=1000.
REQ-036 Data path: req[0]=1, addr0=5, wdata0=8'hA5 -> next cycle de=8'b0010_0000, d=8'hA5; bank word 5 reads 8'hA5 after the edge.
